// File: rtl/tri_pkg.sv
// Shared definitions for the triangle rasterizer and its pixel collector:
// default coordinate width, counter width helper and the collector state encoding.
package tri_pkg;

  localparam int TRI_CW = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  // Pixel counter must hold 0..(1<<(2*cw)) inclusive.
  function automatic int cnt_width(input int cw);
    return 2 * cw + 1;
  endfunction

endpackage

// File: rtl/tri_pixel_collector_if.sv
// Pixel stream in / row drain out bundle of the pixel collector.
// master = rasterizer + consumer side, slave = collector side.
interface tri_pixel_collector_if
  import tri_pkg::*;
#(
  parameter int CW = TRI_CW
);
  localparam int NROW = 1 << CW;
  localparam int CNTW = cnt_width(CW);

  logic            busy_i;
  logic            po_i;
  logic [CW-1:0]   xo_i;
  logic [CW-1:0]   yo_i;
  logic            row_valid;
  logic            row_ready;
  logic [CW-1:0]   row_idx;
  logic [NROW-1:0] row_data;
  logic [CNTW-1:0] pix_count;
  logic            frame_done;
  logic            overrun;
  logic            dup_err;

  modport master (
    output busy_i, po_i, xo_i, yo_i, row_ready,
    input  row_valid, row_idx, row_data, pix_count, frame_done, overrun, dup_err
  );

  modport slave (
    input  busy_i, po_i, xo_i, yo_i, row_ready,
    output row_valid, row_idx, row_data, pix_count, frame_done, overrun, dup_err
  );

endinterface

// File: rtl/tri_bitmap.sv
// NROW x NROW single-bit pixel store: set one bit, clear all, read one row.
// o_hit reports whether the addressed write bit is already set.
module tri_bitmap #(
  parameter int CW = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_wr_en,
  input  logic [CW-1:0]         i_wr_x,
  input  logic [CW-1:0]         i_wr_y,
  input  logic                  i_clr,
  input  logic [CW-1:0]         i_rd_row,
  output logic                  o_hit,
  output logic [(1<<CW)-1:0]    o_row_data
);
  localparam int NROW = 1 << CW;

  // Row y occupies bits [y*NROW +: NROW], so {y,x} is the flat bit index.
  logic [NROW*NROW-1:0] w_flat;

  for (genvar gi = 0; gi < NROW; gi++) begin : g_row
    logic [NROW-1:0] r_row;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_row <= '0;
      end else if (i_clr) begin
        r_row <= '0;
      end else if (i_wr_en && (i_wr_y == CW'(gi))) begin
        r_row[i_wr_x] <= 1'b1;
      end
    end

    assign w_flat[gi*NROW +: NROW] = r_row;
  end

  assign o_hit      = w_flat[{i_wr_y, i_wr_x}];
  assign o_row_data = w_flat[{i_rd_row, {CW{1'b0}}} +: NROW];

endmodule

// File: rtl/tri_pixel_collector.sv
// Captures a rasterizer pixel stream into a bitmap and drains it row by row.
// Optional duplicate-pixel detection is enabled by defining TRI_DUP_CHECK_EN.
module tri_pixel_collector
  import tri_pkg::*;
#(
  parameter int CW = TRI_CW
) (
  input  logic                 clk,
  input  logic                 reset,
  tri_pixel_collector_if.slave bus
);
  localparam int NROW = 1 << CW;
  localparam int CNTW = cnt_width(CW);
  localparam logic [CNTW-1:0] PIX_MAX = CNTW'(1 << (2 * CW));

  state_t          r_state;
  logic            r_busy_q;
  logic            r_row_valid;
  logic [CW-1:0]   r_row_idx;
  logic [CNTW-1:0] r_pix_count;
  logic            r_frame_done;
  logic            r_overrun;

  logic            w_hit;
  logic [NROW-1:0] w_row_bits;

  wire w_eof      = r_busy_q & ~bus.busy_i;
  wire w_capture  = bus.po_i & (r_state != ST_DRAIN);
  wire w_new_pix  = w_capture & ~w_hit & (r_pix_count < PIX_MAX);
  wire w_accept   = r_row_valid & bus.row_ready;
  wire w_last_row = w_accept & (r_row_idx == CW'(NROW - 1));

  tri_bitmap #(.CW(CW)) u_bitmap (
    .clk        (clk),
    .reset      (reset),
    .i_wr_en    (w_capture),
    .i_wr_x     (bus.xo_i),
    .i_wr_y     (bus.yo_i),
    .i_clr      (w_last_row),
    .i_rd_row   (r_row_idx),
    .o_hit      (w_hit),
    .o_row_data (w_row_bits)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_busy_q     <= 1'b0;
      r_row_valid  <= 1'b0;
      r_row_idx    <= '0;
      r_pix_count  <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_busy_q     <= bus.busy_i;
      r_frame_done <= 1'b0;
      if (w_new_pix) begin
        r_pix_count <= r_pix_count + 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.busy_i) begin
            r_state <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (w_eof) begin
            r_state     <= ST_DRAIN;
            r_row_valid <= 1'b1;
            r_row_idx   <= '0;
          end
        end
        ST_DRAIN: begin
          // A new frame starting now cannot be captured; flag it instead.
          if (bus.busy_i && !r_busy_q) begin
            r_overrun <= 1'b1;
          end
          if (w_accept) begin
            r_row_idx <= r_row_idx + 1'b1;
          end
          if (w_last_row) begin
            r_row_valid  <= 1'b0;
            r_frame_done <= 1'b1;
            r_pix_count  <= '0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef TRI_DUP_CHECK_EN
  logic r_dup_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dup_err <= 1'b0;
    end else if (w_capture && w_hit) begin
      r_dup_err <= 1'b1;
    end
  end

  assign bus.dup_err = r_dup_err;
`else
  assign bus.dup_err = 1'b0;
`endif

  assign bus.row_valid  = r_row_valid;
  assign bus.row_idx    = r_row_idx;
  assign bus.row_data   = r_row_valid ? w_row_bits : '0;
  assign bus.pix_count  = r_pix_count;
  assign bus.frame_done = r_frame_done;
  assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_tri_pixel_collector.sv
// Directed bench for tri_pixel_collector: frames of hand-placed pixels, drain
// with optional backpressure / overrun injection, reset checks.
module tb_tri_pixel_collector;
  import tri_pkg::*;

  localparam int CW   = TRI_CW;
  localparam int NROW = 1 << CW;

`ifdef TRI_DUP_CHECK_EN
  localparam logic EXP_DUP = 1'b1;
`else
  localparam logic EXP_DUP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [NROW-1:0] exp_rows [NROW];

  tri_pixel_collector_if #(.CW(CW)) bus ();

  tri_pixel_collector #(.CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input int x, input int y, input logic busy);
    bus.busy_i = busy;
    bus.po_i   = 1'b1;
    bus.xo_i   = CW'(x);
    bus.yo_i   = CW'(y);
    tick();
    bus.po_i   = 1'b0;
  endtask

  task automatic clear_exp();
    for (int r = 0; r < NROW; r++) exp_rows[r] = '0;
  endtask

  // Called right after the eof edge; checks every presented row.
  task automatic drain(input string name, input int exp_cnt, input int stall_row,
                       input int stall_cycles, input int ovr_row);
    for (int r = 0; r < NROW; r++) begin
      check({name, "_valid"}, 32'(bus.row_valid), 32'd1);
      check({name, "_idx"},   32'(bus.row_idx),   32'(r));
      check({name, "_data"},  32'(bus.row_data),  32'(exp_rows[r]));
      check({name, "_cnt"},   32'(bus.pix_count), 32'(exp_cnt));
      check({name, "_fd_lo"}, 32'(bus.frame_done), 32'd0);
      $display("%s row %0d data=0x%02h cnt=%0d", name, bus.row_idx, bus.row_data, bus.pix_count);
      if (r == ovr_row) begin
        bus.busy_i = 1'b1;
        bus.po_i   = 1'b1;
        bus.xo_i   = CW'(1);
        bus.yo_i   = CW'(NROW - 1);
      end else begin
        bus.po_i   = 1'b0;
      end
      if (r == stall_row) begin
        bus.row_ready = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          tick();
          bus.po_i = 1'b0;
          check({name, "_stall_idx"},  32'(bus.row_idx),  32'(r));
          check({name, "_stall_data"}, 32'(bus.row_data), 32'(exp_rows[r]));
          check({name, "_stall_vld"},  32'(bus.row_valid), 32'd1);
        end
        bus.row_ready = 1'b1;
      end
      tick();
    end
    bus.po_i = 1'b0;
    check({name, "_fd"},      32'(bus.frame_done), 32'd1);
    check({name, "_vld_end"}, 32'(bus.row_valid),  32'd0);
    tick();
    check({name, "_fd_pulse"}, 32'(bus.frame_done), 32'd0);
    check({name, "_cnt_clr"},  32'(bus.pix_count),  32'd0);
    $display("%s frame done", name);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_valid"},   32'(bus.row_valid),  32'd0);
    check({name, "_idx"},     32'(bus.row_idx),    32'd0);
    check({name, "_data"},    32'(bus.row_data),   32'd0);
    check({name, "_cnt"},     32'(bus.pix_count),  32'd0);
    check({name, "_fd"},      32'(bus.frame_done), 32'd0);
    check({name, "_overrun"}, 32'(bus.overrun),    32'd0);
    check({name, "_dup"},     32'(bus.dup_err),    32'd0);
  endtask

  initial begin
    bus.busy_i    = 1'b0;
    bus.po_i      = 1'b0;
    bus.xo_i      = '0;
    bus.yo_i      = '0;
    bus.row_ready = 1'b1;
    repeat (2) tick();
    check_all_zero("rst");
    reset = 1'b1;
    tick();
    check_all_zero("rst_rel");

    // 1: four pixels, eof in a pixel-free cycle
    clear_exp();
    exp_rows[0] = 8'h07;
    exp_rows[1] = 8'h01;
    pixel(0, 0, 1'b1);
    pixel(1, 0, 1'b1);
    pixel(2, 0, 1'b1);
    pixel(0, 1, 1'b1);
    check("t1_cnt_mid", 32'(bus.pix_count), 32'd4);
    bus.busy_i = 1'b0;
    tick();
    drain("t1", 4, -1, 0, -1);
    check("t1_dup", 32'(bus.dup_err), 32'd0);

    // 2: last pixel arrives in the eof cycle
    clear_exp();
    exp_rows[7] = 8'h80;
    bus.busy_i = 1'b1;
    tick();
    pixel(7, 7, 1'b0);
    drain("t2", 1, -1, 0, -1);

    // 3: backpressure on row 3
    clear_exp();
    exp_rows[3] = 8'h28;
    pixel(3, 3, 1'b1);
    pixel(5, 3, 1'b1);
    bus.busy_i = 1'b0;
    tick();
    drain("t3", 2, 3, 5, -1);

    // 4: empty frame
    clear_exp();
    bus.busy_i = 1'b1;
    repeat (3) tick();
    bus.busy_i = 1'b0;
    tick();
    drain("t4", 0, -1, 0, -1);

    // 5: new frame starts during drain, then asynchronous reset
    clear_exp();
    exp_rows[6] = 8'h10;
    pixel(4, 6, 1'b1);
    bus.busy_i = 1'b0;
    tick();
    check("t5_ovr_pre", 32'(bus.overrun), 32'd0);
    drain("t5", 1, -1, 0, 2);
    check("t5_overrun", 32'(bus.overrun), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("t5_rst");
    bus.busy_i = 1'b0;
    tick();
    #3;
    reset = 1'b1;
    tick();

    // 6: duplicate pixel
    clear_exp();
    exp_rows[2] = 8'h04;
    pixel(2, 2, 1'b1);
    pixel(2, 2, 1'b1);
    check("t6_dup", 32'(bus.dup_err), 32'(EXP_DUP));
    bus.busy_i = 1'b0;
    tick();
    drain("t6", 1, -1, 0, -1);
    check("t6_dup_sticky", 32'(bus.dup_err), 32'(EXP_DUP));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
